// File: rtl/day1_pkg.sv
// day1_pkg: shared width, byte type and channel encoding for the day-1 demux.
package day1_pkg;
    localparam int DATA_W = 8;
    typedef logic [DATA_W-1:0] byte_t;
    typedef enum logic {CH0 = 1'b0, CH1 = 1'b1} chan_e;
endpackage

// File: rtl/day1_demux_fifo.sv
// day1_demux_fifo: count-based synchronous FIFO; head data reads as zero when empty.
module day1_demux_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push_i,
    input  logic [W-1:0]           data_i,
    input  logic                   pop_i,
    output logic [W-1:0]           data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int PW = $clog2(DEPTH);
    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [PW:0]   count_q, count_d;
    logic          do_push, do_pop;
    // Push is refused when full even if a pop happens in the same cycle.
    always_comb begin
        full_o  = count_q == (PW+1)'(DEPTH);
        empty_o = count_q == '0;
        do_push = push_i && !full_o;
        do_pop  = pop_i && !empty_o;
        wr_d    = do_push ? wr_q + PW'(1) : wr_q;
        rd_d    = do_pop ? rd_q + PW'(1) : rd_q;
        count_d = count_q + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
        data_o  = empty_o ? '0 : mem_q[rd_q];
        count_o = count_q;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end
endmodule

// File: rtl/day1_demux.sv
// day1_demux: steers one byte stream into two output FIFOs chosen by in_sel_i.
module day1_demux #(
    parameter int DATA_W = day1_pkg::DATA_W,
    parameter int DEPTH  = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [DATA_W-1:0]      in_data_i,
    input  logic                   in_sel_i,
    output logic                   out0_valid_o,
    input  logic                   out0_ready_i,
    output logic [DATA_W-1:0]      out0_data_o,
    output logic                   out1_valid_o,
    input  logic                   out1_ready_i,
    output logic [DATA_W-1:0]      out1_data_o,
    output logic [$clog2(DEPTH):0] out0_count_o,
    output logic [$clog2(DEPTH):0] out1_count_o
);
    import day1_pkg::*;
    chan_e sel;
    logic  full0, full1, empty0, empty1, push0, push1;
    // Ready looks only at the selected FIFO, so a full channel never blocks the other.
    always_comb begin
        sel          = chan_e'(in_sel_i);
        in_ready_o   = (sel == CH1) ? !full1 : !full0;
        push0        = in_valid_i && in_ready_o && sel == CH0;
        push1        = in_valid_i && in_ready_o && sel == CH1;
        out0_valid_o = !empty0;
        out1_valid_o = !empty1;
    end
    day1_demux_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_fifo0 (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push0),
        .data_i  (in_data_i),
        .pop_i   (out0_ready_i),
        .data_o  (out0_data_o),
        .full_o  (full0),
        .empty_o (empty0),
        .count_o (out0_count_o)
    );
    day1_demux_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_fifo1 (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push1),
        .data_i  (in_data_i),
        .pop_i   (out1_ready_i),
        .data_o  (out1_data_o),
        .full_o  (full1),
        .empty_o (empty1),
        .count_o (out1_count_o)
    );
endmodule

// File: tb/tb_day1_demux.sv
// tb_day1_demux: directed vector table plus reset sequences for day1_demux.
module tb_day1_demux;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       in_valid, in_ready, in_sel, r0, r1, v0, v1;
    logic [7:0] in_data, d0, d1;
    logic [1:0] c0, c1;
    int         n_tests = 0;
    int         n_fail  = 0;

    day1_demux #(.DATA_W(8), .DEPTH(2)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_data_i    (in_data),
        .in_sel_i     (in_sel),
        .out0_valid_o (v0),
        .out0_ready_i (r0),
        .out0_data_o  (d0),
        .out1_valid_o (v1),
        .out1_ready_i (r1),
        .out1_data_o  (d1),
        .out0_count_o (c0),
        .out1_count_o (c1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v, s;
        logic [7:0] d;
        logic       r0, r1, rdy, v0;
        logic [7:0] d0;
        logic [1:0] c0;
        logic       v1;
        logic [7:0] d1;
        logic [1:0] c1;
    } vec_t;

    vec_t vec [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic ev0, input logic [7:0] ed0, input logic [1:0] ec0,
                            input logic ev1, input logic [7:0] ed1, input logic [1:0] ec1);
        chk({tag, " v0"}, 32'(v0), 32'(ev0));
        chk({tag, " d0"}, 32'(d0), 32'(ed0));
        chk({tag, " c0"}, 32'(c0), 32'(ec0));
        chk({tag, " v1"}, 32'(v1), 32'(ev1));
        chk({tag, " d1"}, 32'(d1), 32'(ed1));
        chk({tag, " c1"}, 32'(c1), 32'(ec1));
    endtask

    task automatic drive(input logic v, input logic s, input logic [7:0] d, input logic rr0, input logic rr1);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
        r0       = rr0;
        r1       = rr1;
    endtask

    initial begin
        //         v     s     d      r0    r1    rdy   v0    d0     c0  v1    d1     c1
        vec[0]  = '{1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA5, 2'd1, 1'b0, 8'h00, 2'd0};
        vec[1]  = '{1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0, 1'b1, 8'h3C, 2'd1};
        vec[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 8'h00, 2'd0};
        vec[3]  = '{1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 2'd1, 1'b0, 8'h00, 2'd0};
        vec[4]  = '{1'b1, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 2'd2, 1'b0, 8'h00, 2'd0};
        vec[5]  = '{1'b1, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 2'd2, 1'b0, 8'h00, 2'd0};
        vec[6]  = '{1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 2'd2, 1'b1, 8'h77, 2'd1};
        vec[7]  = '{1'b1, 1'b0, 8'hAA, 1'b1, 1'b0, 1'b0, 1'b1, 8'h02, 2'd1, 1'b1, 8'h77, 2'd1};
        vec[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0, 1'b1, 8'h77, 2'd1};
        vec[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0, 1'b1, 8'h77, 2'd1};
        vec[10] = '{1'b1, 1'b1, 8'h10, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0, 1'b1, 8'h10, 2'd1};
        vec[11] = '{1'b1, 1'b1, 8'h20, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0, 1'b1, 8'h20, 2'd1};
        vec[12] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 8'h00, 2'd0};
        vec[13] = '{1'b1, 1'b1, 8'h55, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0, 1'b1, 8'h55, 2'd1};
        vec[14] = '{1'b1, 1'b1, 8'h66, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0, 1'b1, 8'h55, 2'd2};
        vec[15] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1, 8'h55, 2'd2};
        vec[16] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0, 1'b1, 8'h55, 2'd2};
        vec[17] = '{1'b1, 1'b0, 8'h99, 1'b0, 1'b0, 1'b1, 1'b1, 8'h99, 2'd1, 1'b1, 8'h55, 2'd2};

        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'($urandom), 1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
            @(posedge clk);
            #1;
            chk_outs($sformatf("reset cyc%0d", i), 1'b0, 8'h00, 2'd0, 1'b0, 8'h00, 2'd0);
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        #2 reset_n = 1'b1;
        #1 chk("ready after reset", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 18; i++) begin
            drive(vec[i].v, vec[i].s, vec[i].d, vec[i].r0, vec[i].r1);
            #1 chk($sformatf("vec%0d rdy", i), 32'(in_ready), 32'(vec[i].rdy));
            @(posedge clk);
            #1;
            chk_outs($sformatf("vec%0d", i), vec[i].v0, vec[i].d0, vec[i].c0, vec[i].v1, vec[i].d1, vec[i].c1);
        end

        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        #2 reset_n = 1'b0;
        #1 chk_outs("async reset", 1'b0, 8'h00, 2'd0, 1'b0, 8'h00, 2'd0);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1 chk_outs("post reset idle", 1'b0, 8'h00, 2'd0, 1'b0, 8'h00, 2'd0);
        drive(1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);
        #1 chk("post reset rdy", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 chk_outs("post reset push", 1'b0, 8'h00, 2'd0, 1'b1, 8'hFF, 2'd1);
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        @(posedge clk);
        #1 chk_outs("post reset drain", 1'b0, 8'h00, 2'd0, 1'b0, 8'h00, 2'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/day1_demux.md
Name: day1_demux

Overview:
- Registered 1-to-2 demultiplexer; the inverse of the day-1 8-bit 2:1 mux.
- One 8-bit input stream with a select bit is steered to one of two output channels.
- Each output channel has its own small FIFO, with valid/ready handshakes on input and on both outputs.
- Sits downstream of a mux stage to split a shared byte stream back into two consumers.

Parameters:
- DATA_W, 8, width of data on the input and on each output channel
- DEPTH, 2, entries per output FIFO; power of two, 2..16

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- in_valid_i  input  1  input byte present
- in_ready_o  output  1  input byte will be accepted this cycle
- in_data_i  input  DATA_W  input byte
- in_sel_i  input  1  destination: 0 -> channel 0, 1 -> channel 1
- out0_valid_o  output  1  channel 0 head entry valid
- out0_ready_i  input  1  channel 0 consumer accepts head entry
- out0_data_o  output  DATA_W  channel 0 head data
- out1_valid_o  output  1  channel 1 head entry valid
- out1_ready_i  input  1  channel 1 consumer accepts head entry
- out1_data_o  output  DATA_W  channel 1 head data
- out0_count_o  output  $clog2(DEPTH)+1  channel 0 occupancy
- out1_count_o  output  $clog2(DEPTH)+1  channel 1 occupancy

Behaviour:
- Reset (asynchronous, reset_n=0):
  - Both FIFOs empty; read/write pointers 0.
  - outN_valid_o=0, outN_data_o=0, outN_count_o=0.
  - in_ready_o=1 once reset_n=1.
- Reset asserted mid-operation: all stored entries are discarded immediately with no pop handshake; outputs take reset values asynchronously.
- Input handshake:
  - in_ready_o = !full[in_sel_i], combinational from in_sel_i and FIFO state only.
  - in_ready_o must not depend on in_valid_i or on outN_ready_i.
  - Transfer occurs when in_valid_i && in_ready_o at a rising edge.
  - Byte is pushed into FIFO[in_sel_i]; the other FIFO is unaffected.
- Output handshake:
  - outN_valid_o = !emptyN.
  - outN_data_o = head entry of FIFO N when valid, 0 when empty.
  - Pop occurs when outN_valid_o && outN_ready_i at a rising edge.
  - Output data must stay stable while valid=1 and ready=0.
- Latency: a byte accepted at edge k is visible on outN_valid_o/outN_data_o after edge k. There is no combinational bypass from input to output.
- Ordering: per-channel FIFO order is preserved; there is no ordering relation between the two channels.
- Full FIFO:
  - in_ready_o=0 whenever the selected FIFO is full, even if that FIFO pops in the same cycle. No push-through-pop on full.
  - The input stalls; a full channel does not block bytes addressed to the other channel. Select is evaluated per cycle.
- Empty FIFO: outN_ready_i while empty has no effect; count does not underflow.
- Simultaneous push and pop on the same non-full, non-empty FIFO: count unchanged, both pointers advance.
- Simultaneous push and pop on an empty FIFO: only the push takes effect (valid is 0, so no pop); count becomes 1.
- Pointers: $clog2(DEPTH) bits, wrap modulo DEPTH. Full/empty are derived from a count register (0..DEPTH).
- outN_count_o is registered and updated on the same edge as the push/pop.
- Both channels may pop in the same cycle independently.
- No protocol checking of in_sel_i when in_valid_i=0; it is don't-care.

Decomposition:
- day1_pkg:
  - DATA_W default constant.
  - typedef logic [DATA_W-1:0] byte_t.
  - typedef enum logic {CH0=1'b0, CH1=1'b1} chan_e.
- Sub-module day1_demux_fifo: synchronous FIFO with push/pop/full/empty/count and async active-low reset.
  - Instantiated twice.
  - Top level holds only the steering and ready logic.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with random inputs -> out0_valid_o=0, out1_valid_o=0, counts 0, data 0; in_ready_o=1 after release.
- Basic routing: push 8'hA5 sel=0, then 8'h3C sel=1, both outN_ready_i=1 -> out0 shows A5 one cycle after its accept, out1 shows 3C one cycle after its accept, each valid for exactly one cycle.
- Fill and stall: out0_ready_i=0, push 8'h01, 8'h02 to ch0 -> out0_count_o=2, in_ready_o=0 with sel=0. Switch sel=1, push 8'h77 -> accepted, out1_data_o=77.
- Drain order: from full ch0 holding 01,02, raise out0_ready_i -> pops 01 then 02, count 2->1->0; in_ready_o for sel=0 returns to 1 after the first pop edge.
- Same-cycle push/pop: ch1 holds 8'h10; push 8'h20 to ch1 while out1_ready_i=1 -> out1_count_o stays 1, next head 20.
- Mid-operation reset: both FIFOs non-empty, pulse reset_n low between edges -> valids drop immediately without a clock edge. After release, no stale data appears; new push 8'hFF sel=1 emerges alone.
